cl_frame_sequencer: RTL and testbench

CL_FRAME_SEQUENCER -- requirements
Module: cl_frame_sequencer

---
 rtl/cl_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_cl_frame_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cl_frame_sequencer.sv
// cl_frame_sequencer -- Camera Link frame timing generator.
//
// Produces one frame per start pulse (or back-to-back frames while
// continuous=1): FV_LEAD lead words, V_ACTIVE lines of H_ACTIVE pixels
// separated by H_BLANK words, then V_BLANK all-zero words.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          frame start request (honoured in IDLE only)
//   continuous     free-run: next frame follows frame_done with no gap
//   abort          stop immediately, no frame_done
//   test_pat       1: {line[7:0], col[15:0]} pattern, 0: pixels from pix_in
//   pix_in         external pixel, valid whenever pix_rd=1
//   pix_rd         pop strobe, 1 the cycle before each active word
//   cl_d           [23:0] pixel, [24] LVAL, [25] DVAL, [26] FVAL, [27] 0
//   busy           frame sequence in progress
//   frame_done     pulse with the last VBLANK word
module cl_frame_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 32,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 64,
  parameter int FV_LEAD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  input  logic        test_pat,
  input  logic [23:0] pix_in,
  output logic        pix_rd,
  output logic [27:0] cl_d,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [15:0] LEAD_LAST = 16'(FV_LEAD - 1);
  localparam logic [15:0] COL_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
  localparam logic [15:0] LINE_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VB_LAST   = 16'(V_BLANK - 1);

  typedef enum logic [2:0] {IDLE, LEAD, ACTIVE, HBLANK, VBLANK} state_e;

  // state_q describes the word currently on cl_d; every registered output
  // is computed from the next state so it lines up with state_q.
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;    // position within LEAD/HBLANK/VBLANK
  logic [15:0] col_q, col_d;
  logic [15:0] line_q, line_d;
  logic        tp_q, tp_d;      // test_pat latched for the whole frame
  logic [27:0] cl_d_q, cl_d_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      line_q  <= '0;
      tp_q    <= 1'b0;
      cl_d_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      line_q  <= line_d;
      tp_q    <= tp_d;
      cl_d_q  <= cl_d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    line_d  = line_q;
    tp_d    = tp_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      col_d   = '0;
      line_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_d = LEAD;
          cnt_d   = '0;
          col_d   = '0;
          line_d  = '0;
          tp_d    = test_pat;
        end
        LEAD: if (cnt_q == LEAD_LAST) begin
          state_d = ACTIVE;
          col_d   = '0;
          line_d  = '0;
        end else cnt_d = cnt_q + 16'd1;
        ACTIVE: if (col_q == COL_LAST) begin
          // no HBLANK after the final line: straight into VBLANK
          state_d = (line_q == LINE_LAST) ? VBLANK : HBLANK;
          cnt_d   = '0;
        end else col_d = col_q + 16'd1;
        HBLANK: if (cnt_q == HB_LAST) begin
          state_d = ACTIVE;
          col_d   = '0;
          line_d  = line_q + 16'd1;
        end else cnt_d = cnt_q + 16'd1;
        VBLANK: if (cnt_q == VB_LAST) begin
          cnt_d  = '0;
          col_d  = '0;
          line_d = '0;
          if (continuous) begin
            state_d = LEAD;
            tp_d    = test_pat;
          end else state_d = IDLE;
        end else cnt_d = cnt_q + 16'd1;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode (registered outputs take their _d here)
  always_comb begin
    cl_d_d = '0;
    unique case (state_d)
      LEAD, HBLANK: cl_d_d[26] = 1'b1;
      ACTIVE: begin
        cl_d_d[26:24] = 3'b111;
        cl_d_d[23:0]  = tp_d ? {line_d[7:0], col_d} : pix_in;
      end
      default: cl_d_d = '0;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == VBLANK) && (cnt_d == VB_LAST);
    // Pop exactly when the next word is an external active pixel.
    pix_rd = !rst && (state_d == ACTIVE) && !tp_d;
  end

  assign cl_d       = cl_d_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_cl_frame_sequencer.sv
module tb_cl_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, continuous, abort, test_pat;
  logic [23:0] pix_in;
  logic        pix_rd, busy, frame_done;
  logic [27:0] cl_d;

  int n_chk = 0;
  int n_err = 0;

  logic [27:0] cd_l [64];
  logic        bz_l [64];
  logic        fd_l [64];
  logic        rd_l [64];
  logic [23:0] pin_l[64];
  int          pops;

  cl_frame_sequencer #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_BLANK(5), .FV_LEAD(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .abort(abort), .test_pat(test_pat), .pix_in(pix_in), .pix_rd(pix_rd),
    .cl_d(cl_d), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle c: inputs driven at the negedge inside cycle c, outputs sampled
  // 1 ns later. The word seen in cycle c was registered at the edge ending c-1.
  task automatic run(input int n, input int s0, input int s1, input int ab,
                     input int rs, input int cont, input int tp);
    int cnt;
    cnt  = 0;
    pops = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start      = (c == s0) || (c == s1);
      abort      = (c == ab);
      rst        = (c == rs);
      continuous = (cont != 0);
      test_pat   = (tp != 0);
      pix_in     = 24'(cnt + 24'h100);
      #1;
      cd_l[c]  = cl_d;
      bz_l[c]  = busy;
      fd_l[c]  = frame_done;
      rd_l[c]  = pix_rd;
      pin_l[c] = pix_in;
      if (pix_rd) begin
        pops++;
        cnt++;
      end
    end
    @(negedge clk);
    start = 0; rst = 0; continuous = 0; abort = 1;
    @(negedge clk);
    abort = 0;
  endtask

  function automatic bit is_lval(input int c);
    return (c >= 3 && c <= 6) || (c >= 9 && c <= 12) || (c >= 15 && c <= 18);
  endfunction

  function automatic bit is_rd(input int c);
    return (c >= 2 && c <= 5) || (c >= 8 && c <= 11) || (c >= 14 && c <= 17);
  endfunction

  // Single non-continuous frame started in cycle 0, observed for 26 cycles.
  task automatic check_frame(input string tag, input int tp);
    for (int c = 0; c < 26; c++) begin
      chk($sformatf("%s_fval@%0d", tag, c), 32'(cd_l[c][26]), 32'(c >= 1 && c <= 18));
      chk($sformatf("%s_lval@%0d", tag, c), 32'(cd_l[c][24]), 32'(is_lval(c)));
      chk($sformatf("%s_dval@%0d", tag, c), 32'(cd_l[c][25]), 32'(is_lval(c)));
      chk($sformatf("%s_done@%0d", tag, c), 32'(fd_l[c]), 32'(c == 23));
      chk($sformatf("%s_busy@%0d", tag, c), 32'(bz_l[c]), 32'(c >= 1 && c <= 23));
      if (!is_lval(c))
        chk($sformatf("%s_zero@%0d", tag, c), 32'(cd_l[c]) & 32'h0fff_ffff & ~32'h0400_0000, 32'h0);
      else if (tp != 0)
        chk($sformatf("%s_pat@%0d", tag, c), 32'(cd_l[c][23:0]),
            32'({8'((c - 3) / 6), 16'((c - 3) % 6)}));
      else
        chk($sformatf("%s_pix@%0d", tag, c), 32'(cd_l[c][23:0]), 32'(pin_l[c-1]));
      if (tp == 0)
        chk($sformatf("%s_rd@%0d", tag, c), 32'(rd_l[c]), 32'(is_rd(c)));
      else
        chk($sformatf("%s_rd@%0d", tag, c), 32'(rd_l[c]), 32'h0);
    end
  endtask

  initial begin
    rst = 1; start = 1; abort = 0; continuous = 0; test_pat = 1; pix_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cl_d", 32'(cl_d), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(frame_done), 32'h0);
    chk("rst_pix_rd", 32'(pix_rd), 32'h0);
    @(negedge clk);
    rst = 0; start = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_idle", 32'(busy), 32'h0);

    // Test pattern frame
    run(26, 0, -1, -1, -1, 0, 1);
    check_frame("tp", 1);
    chk("tp_c9", 32'(cd_l[9][23:0]), 32'h010000);
    chk("tp_c18", 32'(cd_l[18][23:0]), 32'h020003);

    // External pixel frame
    run(26, 0, -1, -1, -1, 0, 0);
    check_frame("ext", 0);
    chk("ext_c3", 32'(cd_l[3][23:0]), 32'(pin_l[2]));
    chk("ext_pops", 32'(pops), 32'd12);

    // Redundant start while busy
    run(26, 0, 5, -1, -1, 0, 1);
    check_frame("restart", 1);

    // Continuous mode
    run(48, 0, -1, -1, -1, 1, 1);
    chk("cont_fval@23", 32'(cd_l[23][26]), 32'h0);
    chk("cont_fval@24", 32'(cd_l[24][26]), 32'h1);
    chk("cont_lval@26", 32'(cd_l[26][24]), 32'h1);
    chk("cont_pat@26", 32'(cd_l[26][23:0]), 32'h000000);
    for (int c = 1; c < 48; c++) begin
      chk($sformatf("cont_done@%0d", c), 32'(fd_l[c]), 32'(c == 23 || c == 46));
      chk($sformatf("cont_busy@%0d", c), 32'(bz_l[c]), 32'h1);
    end

    // Abort mid-line, then restart
    run(16, 0, 12, 10, -1, 0, 0);
    chk("abort_rd@10", 32'(rd_l[10]), 32'h0);
    chk("abort_rd@11", 32'(rd_l[11]), 32'h0);
    chk("abort_cl_d@11", 32'(cd_l[11]), 32'h0);
    chk("abort_busy@11", 32'(bz_l[11]), 32'h0);
    chk("abort_fval@12", 32'(cd_l[12][26]), 32'h0);
    chk("abort_fval@13", 32'(cd_l[13][26]), 32'h1);
    chk("abort_busy@13", 32'(bz_l[13]), 32'h1);
    for (int c = 0; c < 16; c++)
      chk($sformatf("abort_done@%0d", c), 32'(fd_l[c]), 32'h0);

    // start and abort together in IDLE
    run(6, 0, -1, 0, -1, 0, 1);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("sa_busy@%0d", c), 32'(bz_l[c]), 32'h0);
      chk($sformatf("sa_fval@%0d", c), 32'(cd_l[c][26]), 32'h0);
    end

    // Reset mid-frame, no restart without a new start
    run(14, 0, -1, -1, 7, 0, 1);
    chk("rst7_fval@7", 32'(cd_l[7][26]), 32'h1);
    chk("rst7_cl_d@8", 32'(cd_l[8]), 32'h0);
    for (int c = 8; c < 14; c++)
      chk($sformatf("rst7_busy@%0d", c), 32'(bz_l[c]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
